// File: rtl/disk_page_fetch_if.sv
// Bundle between the page fetcher, the disk address generator, the disk RAM and the consumer.
// The fetcher uses the slave modport; the environment uses master.
interface disk_page_fetch_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9
);
    logic [ADDR_W-1:0]   addr;
    logic                reload;
    logic                mem_rd_en;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_rdata;
    logic [4*DATA_W-1:0] page;
    logic                page_valid;
    logic                busy;

    modport master (
        output addr, reload, mem_rdata,
        input  mem_rd_en, mem_addr, page, page_valid, busy
    );

    modport slave (
        input  addr, reload, mem_rdata,
        output mem_rd_en, mem_addr, page, page_valid, busy
    );
endinterface

// File: rtl/disk_page_fetch.sv
// Fetches the four words of a disk page from synchronous RAM and presents them as one wide page.
// Refetches on page-address change or reload; an address change mid-fetch restarts the fetch.
module disk_page_fetch #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9
) (
    input logic               clk,
    input logic               rst,
    disk_page_fetch_if.slave  bus
);
    localparam int unsigned BASE_W = ADDR_W - 2;

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

    state_e              state_q;
    logic [BASE_W-1:0]   last_base_q;
    logic                primed_q;
    logic [1:0]          i_q;
    logic [1:0]          c_q;
    logic [DATA_W-1:0]   stage_q [3];

    logic [BASE_W-1:0]   new_base;
    logic                base_change;
    logic                start;

    assign new_base    = bus.addr[ADDR_W-1:2];
    assign base_change = (new_base != last_base_q);

    // A fresh fetch and an abort-and-restart share the same entry into READ.
    always_comb begin
        start = 1'b0;
        unique case (state_q)
            StIdle:          start = !primed_q || base_change || bus.reload;
            StRead, StDrain: start = base_change;
            default:         start = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            last_base_q    <= '0;
            primed_q       <= 1'b0;
            i_q            <= '0;
            c_q            <= '0;
            for (int k = 0; k < 3; k++) stage_q[k] <= '0;
            bus.mem_rd_en  <= 1'b0;
            bus.mem_addr   <= '0;
            bus.page       <= '0;
            bus.page_valid <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.page_valid <= 1'b0;
            if (start) begin
                last_base_q   <= new_base;
                primed_q      <= 1'b1;
                i_q           <= '0;
                c_q           <= '0;
                bus.mem_rd_en <= 1'b1;
                bus.mem_addr  <= {new_base, 2'b00};
                bus.busy      <= 1'b1;
                state_q       <= StRead;
            end else begin
                unique case (state_q)
                    StIdle: state_q <= StIdle;
                    StRead: begin
                        // Data for the read issued last cycle arrives now.
                        if (i_q != 2'd0) begin
                            stage_q[c_q] <= bus.mem_rdata;
                            c_q          <= c_q + 2'd1;
                        end
                        if (i_q == 2'd3) begin
                            bus.mem_rd_en <= 1'b0;
                            state_q       <= StDrain;
                        end else begin
                            i_q          <= i_q + 2'd1;
                            bus.mem_addr <= {last_base_q, i_q + 2'd1};
                        end
                    end
                    StDrain: begin
                        bus.page       <= {bus.mem_rdata, stage_q[2], stage_q[1], stage_q[0]};
                        bus.page_valid <= 1'b1;
                        bus.busy       <= 1'b0;
                        state_q        <= StDone;
                    end
                    StDone:  state_q <= StIdle;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_disk_page_fetch.sv
// Randomised self-checking bench for disk_page_fetch against a cycle-offset fetch model.
module tb_disk_page_fetch;
    logic clk;
    logic rst;

    disk_page_fetch_if #(.DATA_W(32), .ADDR_W(9)) dif ();

    disk_page_fetch #(.DATA_W(32), .ADDR_W(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ram [512];

    // Synchronous RAM model: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (dif.mem_rd_en) dif.mem_rdata <= ram[dif.mem_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulse  = 0;
    int n_busy   = 0;

    // Model: m_k is the cycle offset within the current fetch (0 = T0), -1 when none.
    bit           m_primed;
    int           m_last;
    int           m_k;
    logic [127:0] m_page;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [127:0] page_of(input int b);
        logic [127:0] p;
        p = '0;
        for (int w = 0; w < 4; w++) p[32*w +: 32] = ram[b*4 + w];
        return p;
    endfunction

    task automatic model_reset();
        m_primed = 1'b0;
        m_last   = 0;
        m_k      = -1;
        m_page   = '0;
    endtask

    task automatic check_outputs();
        bit rd;
        rd = (m_k >= 0 && m_k <= 3);
        check("busy", 128'(dif.busy), 128'(m_k >= 0 && m_k <= 4));
        check("page_valid", 128'(dif.page_valid), 128'(m_k == 5));
        check("mem_rd_en", 128'(dif.mem_rd_en), 128'(rd));
        if (rd) check("mem_addr", 128'(dif.mem_addr), 128'(m_last * 4 + m_k));
        check("page", dif.page, m_page);
    endtask

    task automatic tick();
        int a_base;
        @(posedge clk);
        a_base = int'(dif.addr[8:2]);
        if (rst) begin
            if (m_k >= 0 && m_k <= 4) begin
                if (a_base != m_last) begin
                    m_last = a_base;
                    m_k    = 0;
                end else begin
                    m_k++;
                end
            end else if (m_k == 5) begin
                m_k = -1;
            end else if (!m_primed || a_base != m_last || dif.reload) begin
                m_primed = 1'b1;
                m_last   = a_base;
                m_k      = 0;
            end
            if (m_k == 5) m_page = page_of(m_last);
        end
        #1;
        if (dif.page_valid) n_pulse++;
        if (dif.busy) n_busy++;
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int t = 0; t < n; t++) tick();
    endtask

    // Assert reset between edges and expect everything cleared immediately.
    task automatic async_reset(input int hold);
        #1;
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_page", dif.page, 128'd0);
        check("rst_valid", 128'(dif.page_valid), 128'd0);
        check("rst_busy", 128'(dif.busy), 128'd0);
        check("rst_rd_en", 128'(dif.mem_rd_en), 128'd0);
        check("rst_mem_addr", 128'(dif.mem_addr), 128'd0);
        ticks(hold);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [127:0] p;
        for (int i = 0; i < 512; i++) ram[i] = 32'(i + 'h100);
        rst        = 1'b0;
        dif.addr   = '0;
        dif.reload = 1'b0;
        model_reset();
        #3;
        check_outputs();
        ticks(2);
        @(negedge clk);
        rst = 1'b1;

        // First fetch after reset, addr 0.
        ticks(8);
        p = {32'h103, 32'h102, 32'h101, 32'h100};
        check("tp_reset_page", dif.page, p);

        // Step 0 -> 4 while idle.
        dif.addr = 9'd4;
        n_pulse = 0;
        n_busy = 0;
        ticks(9);
        check("tp_step_pulses", 128'(n_pulse), 128'd1);
        check("tp_step_busy", 128'(n_busy), 128'd5);
        p = {32'h107, 32'h106, 32'h105, 32'h104};
        check("tp_step_page", dif.page, p);

        // Re-fetch page 4 by reload, change to 8 at T2.
        dif.reload = 1'b1;
        tick();
        dif.reload = 1'b0;
        n_pulse = 0;
        ticks(2);
        dif.addr = 9'd8;
        ticks(10);
        check("tp_abort_pulses", 128'(n_pulse), 128'd1);
        p = {32'h10b, 32'h10a, 32'h109, 32'h108};
        check("tp_abort_page", dif.page, p);

        // Last page, no wrap.
        dif.addr = 9'd508;
        ticks(8);
        p = {32'h2ff, 32'h2fe, 32'h2fd, 32'h2fc};
        check("tp_top_page", dif.page, p);

        // Reload while idle on unchanged addr 12.
        dif.addr = 9'd12;
        ticks(8);
        n_pulse = 0;
        dif.reload = 1'b1;
        tick();
        dif.reload = 1'b0;
        ticks(8);
        check("tp_reload_pulses", 128'(n_pulse), 128'd1);

        // Reload while busy is ignored.
        dif.addr = 9'd16;
        n_pulse = 0;
        ticks(3);
        dif.reload = 1'b1;
        tick();
        dif.reload = 1'b0;
        ticks(10);
        check("tp_busy_reload_pulses", 128'(n_pulse), 128'd1);

        // Reset at T3 of a fetch, then a fresh fetch completes.
        dif.addr = 9'd20;
        ticks(4);
        async_reset(2);
        ticks(8);
        check("tp_rst_refetch_page", dif.page, page_of(5));

        // Randomised phase with fresh RAM contents.
        async_reset(1);
        for (int i = 0; i < 512; i++) ram[i] = $urandom();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 7) == 0)
                dif.addr = 9'($urandom_range(0, 511));
            else if ($urandom_range(0, 5) == 0)
                dif.addr[1:0] = 2'($urandom_range(0, 3));
            dif.reload = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 399) == 0) begin
                dif.reload = 1'b0;
                async_reset($urandom_range(0, 2));
            end else begin
                tick();
            end
        end
        dif.reload = 1'b0;
        ticks(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/disk_page_fetch.md
# disk_page_fetch

Responder side of the disk page-address path: consumes the 9-bit page address produced by the disk address generator (always a multiple of 4), reads the four 32-bit words of that page from the synchronous disk RAM, and presents them as one 128-bit page with a one-cycle valid strobe. It sits between the address generator and the display/consumer logic. A new fetch starts automatically whenever the incoming address changes, and on an explicit reload request.

## Interface
Parameters:
- DATA_W, 32, width of one disk RAM word.
- ADDR_W, 9, width of the page/word address.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- addr  input  ADDR_W  page base address from the address generator. Bits [1:0] are ignored; the base is {addr[8:2],2'b00}.
- reload  input  1  single-cycle request to re-fetch the current page.
- mem_rd_en  output  1  read strobe to the disk RAM.
- mem_addr  output  ADDR_W  word address to the disk RAM.
- mem_rdata  input  DATA_W  RAM read data, valid one cycle after mem_rd_en.
- page  output  4*DATA_W  last completed page. Word k occupies page[32k+31:32k].
- page_valid  output  1  one-cycle pulse when page is updated.
- busy  output  1  high while a fetch is in flight.

## Operation
- Registers:
  - last_base (7 bits): page index of the last accepted fetch.
  - primed flag.
  - FSM state.
  - issue index i (2 bits).
  - capture index c (2 bits).
  - 4-word staging buffer.
  - page register.
- Reset values:
  - FSM = IDLE; primed = 0; last_base = 0.
  - page = 0; page_valid = 0; busy = 0; mem_rd_en = 0; mem_addr = 0.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - Start a fetch when primed = 0, when addr[8:2] != last_base, or when reload = 1.
  - On start: latch base = addr[8:2] into last_base, set primed = 1, clear i and c, and go to READ.
- READ:
  - Drive mem_rd_en = 1 and mem_addr = {last_base, i}.
  - Increment i each cycle.
  - From the second READ cycle onward, capture mem_rdata into staging word c and increment c.
  - After i = 3 is issued, go to DRAIN.
- DRAIN:
  - mem_rd_en = 0.
  - Capture mem_rdata as word 3.
  - Go to DONE.
- DONE:
  - Copy staging into page and pulse page_valid.
  - Go to IDLE.
- Abort: in READ or DRAIN, if addr[8:2] != last_base, the fetch is abandoned.
  - The next state is READ with the new base latched and i = c = 0.
  - page is not updated and no page_valid is issued for the abandoned page.
- reload while busy is ignored; it is not queued.
- Address arithmetic:
  - mem_addr = {last_base, i} never carries out of ADDR_W.
  - Page 127 reads words 508..511; no wrap occurs.
- busy = 1 in READ and DRAIN, 0 in IDLE and DONE.

## Timing
- T0 is the first READ cycle.
  - mem_rd_en = 1 during T0..T3, with mem_addr = base+0..base+3.
  - mem_rdata words 0..3 are sampled at the end of T1..T4.
  - T4 = DRAIN, T5 = DONE: page_valid = 1 during T5 only, and page holds the new value from T5.
- The start condition is sampled in IDLE; T0 is the next cycle.
- Trigger-to-valid latency: 6 cycles (trigger sampled at cycle N, page_valid at N+6).
- After reset is released, the first fetch (primed = 0) begins at T0 = the second clock edge after rst rises, and fetches addr as it is then.
- Back-to-back:
  - An address change during DONE is seen in the following IDLE cycle.
  - Minimum period between page_valid pulses is 7 cycles.
- An abort takes effect at the next edge: the new T0 follows the cycle in which the change is seen.
- Asserting rst mid-fetch immediately clears all outputs and state; no partial page is ever exposed.

## Test plan
- Reset then release with addr=0 and RAM[i]=i+0x100:
  - mem_addr sequence 0,1,2,3;
  - page_valid at T5;
  - page = {0x103,0x102,0x101,0x100}.
- Step addr 0→4 while idle:
  - fetch of words 4..7;
  - page_valid exactly once, 6 cycles after the change;
  - busy high for 5 cycles.
- Change addr 4→8 at T2 of an in-flight fetch:
  - no page_valid for page 4;
  - mem_addr restarts at 8;
  - page = words 8..11 on a single pulse.
- addr=508 (page 127):
  - mem_addr 508..511, no wrap;
  - page assembled correctly.
- reload pulse while idle on an unchanged addr=12:
  - re-fetch of words 12..15 and one page_valid.
- reload pulse while busy:
  - ignored, giving exactly one page_valid.
- Drop rst at T3:
  - outputs zero at once;
  - after release, a fresh fetch of the current addr completes.
